// File: rtl/mem_pkg.sv
// Shared definitions for the unified memory responder: funct3 codes, FSM encoding, lane width.
package mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_D = 2'd1,
    SERVE_I = 2'd2
  } state_e;
endpackage

// File: rtl/byte_lane_unit.sv
// Combinational RISC-V lane handling: store byte enables / replicated write data and load
// lane select with sign/zero extension. Offsets are forced to natural alignment.
module byte_lane_unit
  import mem_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [31:0]     wdata,
  input  logic [31:0]     rword,
  output logic [BE_W-1:0] be,
  output logic [31:0]     wdata_sh,
  output logic [31:0]     rdata_ext,
  output logic            misalign
);
  logic [1:0]  off;
  logic [31:0] sh_word;

  always_comb begin
    off      = 2'b00;
    misalign = 1'b0;
    case (funct3)
      F3_B, F3_BU: off = addr_lo;
      F3_H, F3_HU: begin
        off      = {addr_lo[1], 1'b0};
        misalign = addr_lo[0];
      end
      F3_W:        misalign = |addr_lo;
      default:     off = 2'b00;
    endcase
  end

  assign sh_word = rword >> {off, 3'b000};

  // BU/HU store encodings behave as B/H; invalid codes enable no lanes.
  always_comb begin
    be        = '0;
    wdata_sh  = wdata;
    rdata_ext = rword;
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << off;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = (funct3 == F3_B) ? {{24{sh_word[7]}}, sh_word[7:0]}
                                     : {24'h0, sh_word[7:0]};
      end
      F3_H, F3_HU: begin
        be        = 4'b0011 << off;
        wdata_sh  = {2{wdata[15:0]}};
        rdata_ext = (funct3 == F3_H) ? {{16{sh_word[15]}}, sh_word[15:0]}
                                     : {16'h0, sh_word[15:0]};
      end
      F3_W: begin
        be        = 4'b1111;
        rdata_ext = rword;
      end
      default: begin
        be        = '0;
        rdata_ext = rword;
      end
    endcase
  end
endmodule

// File: rtl/unified_mem_responder.sv
// Single-port word RAM serving fetch and data channels, data priority with starvation guard.
// Define MEM_MISALIGN_ERR_EN to flag misaligned H/W accesses via d_err instead of truncating.
module unified_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS  = 128,
  parameter int AW           = 7,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        if_stall
);
  localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_err_q, d_err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0]   d_idx, i_idx;
  logic [31:0]     d_word, i_word;
  logic [BE_W-1:0] lane_be;
  logic [31:0]     lane_wdata, lane_rdata;
  logic            lane_misal, misal;
  logic            grant_d, grant_i, mem_we;

  assign d_idx  = d_addr[AW+1:2];
  assign i_idx  = if_addr[AW+1:2];
  assign d_word = mem[d_idx];
  assign i_word = mem[i_idx];

  byte_lane_unit u_lane (
    .funct3    (d_funct3),
    .addr_lo   (d_addr[1:0]),
    .wdata     (d_wdata),
    .rword     (d_word),
    .be        (lane_be),
    .wdata_sh  (lane_wdata),
    .rdata_ext (lane_rdata),
    .misalign  (lane_misal)
  );

  logic unused_bits;
`ifdef MEM_MISALIGN_ERR_EN
  assign misal       = lane_misal;
  assign unused_bits = ^{if_addr[31:AW+2], if_addr[1:0], d_addr[31:AW+2]};
`else
  assign misal       = 1'b0;
  assign unused_bits = ^{if_addr[31:AW+2], if_addr[1:0], d_addr[31:AW+2], lane_misal};
`endif

  always_comb begin
    grant_d      = d_req && !(if_req && (starve_cnt_q == SLIM));
    grant_i      = !grant_d && if_req;
    state_d      = IDLE;
    starve_cnt_d = starve_cnt_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    d_err_d      = 1'b0;
    if (grant_d) begin
      state_d   = SERVE_D;
      d_err_d   = misal;
      d_rdata_d = (d_we || misal) ? 32'h0 : lane_rdata;
    end else if (grant_i) begin
      state_d    = SERVE_I;
      if_rdata_d = i_word;
    end
    // Counter measures how long a waiting fetch has been passed over.
    if (!if_req || grant_i)
      starve_cnt_d = 4'd0;
    else if (grant_d && starve_cnt_q < SLIM)
      starve_cnt_d = starve_cnt_q + 4'd1;
  end

  assign mem_we = grant_d && d_we && !misal && rst;

  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++)
      if (mem_we && lane_be[b]) mem[d_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      if_rdata_q   <= 32'h0;
      d_rdata_q    <= 32'h0;
      d_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      d_err_q      <= d_err_d;
    end
  end

  assign if_ack   = (state_q == SERVE_I);
  assign d_ack    = (state_q == SERVE_D);
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign d_err    = d_err_q;
  assign if_stall = if_req && !grant_i;
endmodule

// File: tb/tb_unified_mem_responder.sv
// Directed bench for unified_mem_responder: vector table for lane handling plus
// hand sequences for reset, starvation and back-to-back handshakes.
module tb_unified_mem_responder;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_funct3 = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        if_stall;

  unified_mem_responder dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err), .if_stall(if_stall)
  );

  always #5 clk = ~clk;

`ifdef MEM_MISALIGN_ERR_EN
  localparam logic [31:0] MIS_LW   = 32'h0;
  localparam logic [31:0] MIS_LH   = 32'h0;
  localparam logic        MIS_ERR  = 1'b1;
  localparam logic [31:0] AFTER_SH = 32'hDEAD55EF;
`else
  localparam logic [31:0] MIS_LW   = 32'hDEAD55EF;
  localparam logic [31:0] MIS_LH   = 32'hFFFFDEAD;
  localparam logic        MIS_ERR  = 1'b0;
  localparam logic [31:0] AFTER_SH = 32'hDEADBEEF;
`endif

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] rd, logic er);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.exp_rd = rd; v.exp_err = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %h required %h", nm, act, exp);
  endtask

  task automatic d_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic ack, output logic [31:0] rd,
                      output logic err);
    d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd; d_req = 1'b1;
    @(posedge clk); #1;
    ack = d_ack; rd = d_rdata; err = d_err;
    d_req = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_d_ack"},    {31'h0, d_ack},  32'h0);
    chk({nm, "_if_ack"},   {31'h0, if_ack}, 32'h0);
    chk({nm, "_d_err"},    {31'h0, d_err},  32'h0);
    chk({nm, "_d_rdata"},  d_rdata,         32'h0);
    chk({nm, "_if_rdata"}, if_rdata,        32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        ack, err;
    logic [31:0] rd;
    string       pat;

    // Reset state
    #1;
    chk_all_zero("reset");
    chk("reset_if_stall", {31'h0, if_stall}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;

    // Reset mid-ack: store completes into RAM, ack dropped by reset
    d_op(1'b1, F3_W, 32'h20, 32'hA5A5A5A5, ack, rd, err);
    chk("rst_pre_ack", {31'h0, ack}, 32'h1);
    rst = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(posedge clk); #1;
    chk_all_zero("rst_hold");
    @(negedge clk); rst = 1'b1;
    d_op(1'b0, F3_W, 32'h20, 32'h0, ack, rd, err);
    chk("rst_post_ack", {31'h0, ack}, 32'h1);
    chk("rst_post_rd",  rd, 32'hA5A5A5A5);

    // Lane handling vector table
    vt.push_back(mk(1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        0));
    vt.push_back(mk(0, F3_B,  32'h13, 32'h0,        32'hFFFFFFDE, 0));
    vt.push_back(mk(0, F3_BU, 32'h13, 32'h0,        32'h000000DE, 0));
    vt.push_back(mk(0, F3_H,  32'h12, 32'h0,        32'hFFFFDEAD, 0));
    vt.push_back(mk(0, F3_HU, 32'h12, 32'h0,        32'h0000DEAD, 0));
    vt.push_back(mk(0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 0));
    vt.push_back(mk(1, F3_B,  32'h11, 32'h55,       32'h0,        0));
    vt.push_back(mk(0, F3_W,  32'h10, 32'h0,        32'hDEAD55EF, 0));
    vt.push_back(mk(1, F3_W,  32'h14, 32'h11223344, 32'h0,        0));
    vt.push_back(mk(1, F3_H,  32'h16, 32'hCAFE8001, 32'h0,        0));
    vt.push_back(mk(0, F3_W,  32'h14, 32'h0,        32'h80013344, 0));
    vt.push_back(mk(0, F3_H,  32'h16, 32'h0,        32'hFFFF8001, 0));
    vt.push_back(mk(0, F3_B,  32'h15, 32'h0,        32'h00000033, 0));
    vt.push_back(mk(0, F3_B,  32'h17, 32'h0,        32'hFFFFFF80, 0));
    vt.push_back(mk(0, F3_W,  32'h210, 32'h0,       32'hDEAD55EF, 0));
    vt.push_back(mk(0, F3_W,  32'h80000014, 32'h0,  32'h80013344, 0));
    vt.push_back(mk(0, 3'b011, 32'h10, 32'h0,       32'hDEAD55EF, 0));
    vt.push_back(mk(1, 3'b111, 32'h10, 32'hFFFFFFFF, 32'h0,       0));
    vt.push_back(mk(0, F3_W,  32'h10, 32'h0,        32'hDEAD55EF, 0));
    vt.push_back(mk(0, F3_W,  32'h12, 32'h0,        MIS_LW,       MIS_ERR));
    vt.push_back(mk(1, F3_H,  32'h11, 32'h0000BEEF, 32'h0,        MIS_ERR));
    vt.push_back(mk(0, F3_W,  32'h10, 32'h0,        AFTER_SH,     0));
    vt.push_back(mk(0, F3_H,  32'h13, 32'h0,        MIS_LH,       MIS_ERR));

    for (int i = 0; i < vt.size(); i++) begin
      d_op(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, ack, rd, err);
      chk($sformatf("vec%0d_ack", i), {31'h0, ack}, 32'h1);
      chk($sformatf("vec%0d_rd",  i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, vt[i].exp_err});
    end

    // Idle cycle: no spurious ack
    @(posedge clk); #1;
    chk("idle_d_ack",  {31'h0, d_ack},  32'h0);
    chk("idle_if_ack", {31'h0, if_ack}, 32'h0);

    // Fetch alone: no stall, low address bits ignored
    if_addr = 32'h13; if_req = 1'b1;
    #1;
    chk("fetch_stall", {31'h0, if_stall}, 32'h0);
    @(posedge clk); #1;
    chk("fetch_ack", {31'h0, if_ack}, 32'h1);
    chk("fetch_rd",  if_rdata, AFTER_SH);
    if_addr = 32'h14;
    @(posedge clk); #1;
    chk("fetch2_ack", {31'h0, if_ack}, 32'h1);
    chk("fetch2_rd",  if_rdata, 32'h80013344);
    if_req = 1'b0;

    // Both requesters held high: D,D,D,D,I repeating
    pat = "DDDDIDDDDI";
    d_we = 1'b0; d_funct3 = F3_W; d_addr = 32'h14; d_req = 1'b1;
    if_addr = 32'h10; if_req = 1'b1;
    for (int k = 0; k < pat.len(); k++) begin
      #1;
      chk($sformatf("starve%0d_stall", k), {31'h0, if_stall}, {31'h0, pat[k] == "D"});
      @(posedge clk); #1;
      chk($sformatf("starve%0d_d_ack", k),  {31'h0, d_ack},  {31'h0, pat[k] == "D"});
      chk($sformatf("starve%0d_if_ack", k), {31'h0, if_ack}, {31'h0, pat[k] == "I"});
      if (pat[k] == "I") chk($sformatf("starve%0d_if_rd", k), if_rdata, AFTER_SH);
      else               chk($sformatf("starve%0d_d_rd", k),  d_rdata,  32'h80013344);
    end
    d_req = 1'b0; if_req = 1'b0;
    @(posedge clk); #1;

    // Back-to-back data requests across three addresses
    d_we = 1'b0; d_funct3 = F3_W; d_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] a, e;
      case (k)
        0:       begin a = 32'h10; e = AFTER_SH;      end
        1:       begin a = 32'h14; e = 32'h80013344; end
        default: begin a = 32'h20; e = 32'hA5A5A5A5; end
      endcase
      d_addr = a;
      @(posedge clk); #1;
      chk($sformatf("b2b%0d_ack", k), {31'h0, d_ack}, 32'h1);
      chk($sformatf("b2b%0d_rd",  k), d_rdata, e);
    end
    d_req = 1'b0;
    @(posedge clk); #1;
    chk("b2b_after_ack", {31'h0, d_ack}, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
